// File: rtl/vector_pkg.sv
// Shared types for the display-list ping-pong store: writer and reader FSM states.
package vector_pkg;

    typedef enum logic {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } dl_wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DRAW = 1'b1
    } dl_rstate_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/dl_bank_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
// A {bank, offset} address maps to bank*DEPTH+offset.
module dl_bank_ram #(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH    = 18,
    parameter int DEPTH        = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_bank,
    input  logic [ADDRESSWIDTH-1:0] wr_offset,
    input  logic [DATAWIDTH-1:0]    wr_data,
    input  logic                    rd_bank,
    input  logic [ADDRESSWIDTH-1:0] rd_offset,
    output logic [DATAWIDTH-1:0]    rd_data
);

    localparam int IW = $clog2(2 * DEPTH);
    localparam logic [ADDRESSWIDTH-1:0] DEPTH_A = ADDRESSWIDTH'(DEPTH);

    logic [DATAWIDTH-1:0] mem [2*DEPTH];

    function automatic logic [IW-1:0] to_index(input logic bank,
                                               input logic [ADDRESSWIDTH-1:0] offset);
        return (bank ? IW'(DEPTH) : IW'(0)) + IW'(offset);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[to_index(wr_bank, wr_offset)] <= wr_data;
        end
    end

    // Out-of-range offsets read as zero instead of aliasing into the other bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_offset < DEPTH_A) begin
            rd_data <= mem[to_index(rd_bank, rd_offset)];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/display_list_pingpong.sv
// Double-buffered display-list store: the builder fills the back bank while the
// display draws the front bank; banks swap only on a frame boundary (go/halt).
module display_list_pingpong
    import vector_pkg::*;
#(
    parameter int ADDRESSWIDTH = 16,
    parameter int DATAWIDTH    = 18,
    parameter int DEPTH        = 1000,
    parameter int REPEAT_LAST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATAWIDTH-1:0]    wr_data,
    input  logic                    wr_commit,
    output logic                    wr_ready,
    output logic                    wr_overflow,
    input  logic [ADDRESSWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0]    rd_data,
    output logic [ADDRESSWIDTH-1:0] rd_len,
    output logic                    go,
    input  logic                    halt,
    output logic [FRAME_CNT_W-1:0]  frame_cnt
);

    localparam logic [ADDRESSWIDTH-1:0] DEPTH_A = ADDRESSWIDTH'(DEPTH);

    dl_wstate_t              wstate;
    dl_rstate_t              rstate;
    logic                    pending;
    logic                    bank_sel;
    logic [ADDRESSWIDTH-1:0] wr_ptr;
    logic [ADDRESSWIDTH-1:0] back_len;
    logic [ADDRESSWIDTH-1:0] front_len;

    logic                    filling;
    logic                    write_ok;
    logic                    write_drop;
    logic [ADDRESSWIDTH-1:0] eff_len;
    logic                    commit_ok;
    logic                    pending_eff;
    logic                    halt_draw;
    logic                    swap;
    logic                    redraw;
    logic [ADDRESSWIDTH-1:0] next_len;

    // A commit in the same cycle as a write includes that word, and a commit in
    // the same cycle as a swap opportunity is treated as already pending.
    assign filling     = (wstate == W_FILL);
    assign write_ok    = filling && wr_en && (wr_ptr < DEPTH_A);
    assign write_drop  = filling && wr_en && !(wr_ptr < DEPTH_A);
    assign eff_len     = wr_ptr + ADDRESSWIDTH'(write_ok);
    assign commit_ok   = filling && wr_commit && (eff_len != '0);
    assign pending_eff = pending || commit_ok;
    assign halt_draw   = (rstate == R_DRAW) && halt;
    assign swap        = pending_eff && ((rstate == R_IDLE) || halt_draw);
    assign redraw      = halt_draw && !pending_eff;
    assign next_len    = commit_ok ? eff_len : back_len;

    assign wr_ready = filling;
    assign rd_len   = front_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= W_FILL;
            rstate      <= R_IDLE;
            pending     <= 1'b0;
            bank_sel    <= 1'b0;
            wr_ptr      <= '0;
            back_len    <= '0;
            front_len   <= '0;
            go          <= 1'b0;
            frame_cnt   <= '0;
            wr_overflow <= 1'b0;
        end else begin
            go <= 1'b0;
            if (write_ok) begin
                wr_ptr <= eff_len;
            end
            if (write_drop) begin
                wr_overflow <= 1'b1;
            end
            if (commit_ok) begin
                back_len    <= eff_len;
                pending     <= 1'b1;
                wstate      <= W_WAIT;
                wr_overflow <= 1'b0;
            end
            // Swap overrides the commit bookkeeping above: the back frame moves straight to the front.
            if (swap) begin
                bank_sel  <= ~bank_sel;
                front_len <= next_len;
                pending   <= 1'b0;
                wstate    <= W_FILL;
                wr_ptr    <= '0;
                rstate    <= R_DRAW;
                go        <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (redraw) begin
                if (REPEAT_LAST != 0) begin
                    go        <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    rstate <= R_IDLE;
                end
            end
        end
    end

    dl_bank_ram #(
        .ADDRESSWIDTH(ADDRESSWIDTH),
        .DATAWIDTH   (DATAWIDTH),
        .DEPTH       (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (write_ok),
        .wr_bank  (~bank_sel),
        .wr_offset(wr_ptr),
        .wr_data  (wr_data),
        .rd_bank  (bank_sel),
        .rd_offset(rd_addr),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_display_list_pingpong.sv
// Bench for display_list_pingpong: two instances (REPEAT_LAST=1 and 0) share directed
// stimulus and are checked against a frame-level model plus literal expectations.
module tb_display_list_pingpong;

    localparam int AW    = 16;
    localparam int DW    = 18;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_commit = 1'b0;
    logic          halt = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          wr_ready_s    [2];
    logic          wr_overflow_s [2];
    logic          go_s          [2];
    logic [DW-1:0] rd_data_s     [2];
    logic [AW-1:0] rd_len_s      [2];
    logic [15:0]   frame_cnt_s   [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_list_pingpong #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .REPEAT_LAST(1)) dut_rep (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready_s[0]), .wr_overflow(wr_overflow_s[0]), .rd_addr(rd_addr),
        .rd_data(rd_data_s[0]), .rd_len(rd_len_s[0]), .go(go_s[0]), .halt(halt),
        .frame_cnt(frame_cnt_s[0])
    );

    display_list_pingpong #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH), .REPEAT_LAST(0)) dut_idle (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_ready(wr_ready_s[1]), .wr_overflow(wr_overflow_s[1]), .rd_addr(rd_addr),
        .rd_data(rd_data_s[1]), .rd_len(rd_len_s[1]), .go(go_s[1]), .halt(halt),
        .frame_cnt(frame_cnt_s[1])
    );

    // Frame-level model: frames are copied as whole word lists, no bank bookkeeping.
    logic [DW-1:0] m_build [2][DEPTH];
    logic [DW-1:0] m_pend  [2][DEPTH];
    logic [DW-1:0] m_front [2][DEPTH];
    int            m_build_n [2];
    int            m_pend_n  [2];
    int            m_front_n [2];
    bit            m_has_pend[2];
    bit            m_filling [2];
    bit            m_drawing [2];
    bit            m_go      [2];
    int            m_cnt     [2];
    bit            m_ovf     [2];
    logic [DW-1:0] m_rd      [2];
    bit            m_rd_ok   [2];
    bit            model_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input int i, input bit rep);
        bit go_next;
        go_next = 1'b0;
        if (rd_addr >= AW'(DEPTH)) begin
            m_rd_ok[i] = 1'b1;
            m_rd[i]    = '0;
        end else if (int'(rd_addr) < m_front_n[i]) begin
            m_rd_ok[i] = 1'b1;
            m_rd[i]    = m_front[i][int'(rd_addr)];
        end else begin
            m_rd_ok[i] = 1'b0;
        end
        if (rst) begin
            m_build_n[i]  = 0;
            m_pend_n[i]   = 0;
            m_front_n[i]  = 0;
            m_has_pend[i] = 1'b0;
            m_filling[i]  = 1'b1;
            m_drawing[i]  = 1'b0;
            m_go[i]       = 1'b0;
            m_cnt[i]      = 0;
            m_ovf[i]      = 1'b0;
            m_rd_ok[i]    = 1'b1;
            m_rd[i]       = '0;
            return;
        end
        if (m_filling[i]) begin
            if (wr_en) begin
                if (m_build_n[i] < DEPTH) begin
                    m_build[i][m_build_n[i]] = wr_data;
                    m_build_n[i]++;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
            if (wr_commit && m_build_n[i] > 0) begin
                for (int k = 0; k < DEPTH; k++) m_pend[i][k] = m_build[i][k];
                m_pend_n[i]   = m_build_n[i];
                m_has_pend[i] = 1'b1;
                m_filling[i]  = 1'b0;
                m_ovf[i]      = 1'b0;
            end
        end
        if (m_has_pend[i] && (!m_drawing[i] || halt)) begin
            for (int k = 0; k < DEPTH; k++) m_front[i][k] = m_pend[i][k];
            m_front_n[i]  = m_pend_n[i];
            m_has_pend[i] = 1'b0;
            m_build_n[i]  = 0;
            m_filling[i]  = 1'b1;
            m_drawing[i]  = 1'b1;
            go_next       = 1'b1;
            m_cnt[i]++;
        end else if (m_drawing[i] && halt) begin
            if (rep) begin
                go_next = 1'b1;
                m_cnt[i]++;
            end else begin
                m_drawing[i] = 1'b0;
            end
        end
        m_go[i] = go_next;
    endtask

    task automatic checkModel();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("m%0d_go", i), 32'(go_s[i]), 32'(m_go[i]));
            checkOutput($sformatf("m%0d_wr_ready", i), 32'(wr_ready_s[i]), 32'(m_filling[i]));
            checkOutput($sformatf("m%0d_wr_overflow", i), 32'(wr_overflow_s[i]), 32'(m_ovf[i]));
            checkOutput($sformatf("m%0d_rd_len", i), 32'(rd_len_s[i]), 32'(m_front_n[i]));
            checkOutput($sformatf("m%0d_frame_cnt", i), 32'(frame_cnt_s[i]), 32'(m_cnt[i] & 16'hFFFF));
            if (m_rd_ok[i]) begin
                checkOutput($sformatf("m%0d_rd_data", i), 32'(rd_data_s[i]), 32'(m_rd[i]));
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep(0, 1'b1);
            modelStep(1, 1'b0);
            model_on = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) checkModel();
        end
    end

    // One call is one clock: drive inputs, take the edge, return 1 time unit after it.
    task automatic applyStimulus(input bit r, input bit en, input logic [DW-1:0] d,
                                 input bit cm, input bit h, input logic [AW-1:0] a);
        rst       = r;
        wr_en     = en;
        wr_data   = d;
        wr_commit = cm;
        halt      = h;
        rd_addr   = a;
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] WA = 18'h0AAA1, WB = 18'h0BBB2, WC = 18'h0CCC3;
    localparam logic [DW-1:0] WD = 18'h0DDD4, WE = 18'h0EEE5, WF = 18'h0FFF6;
    localparam logic [DW-1:0] WG = 18'h11117, WH = 18'h22228, WI = 18'h33339, WJ = 18'h3444A;

    function automatic logic [DW-1:0] ovfWord(input int k);
        return DW'(32'h10000 + k);
    endfunction

    initial begin
        $display("[TB] start");
        applyStimulus(1, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("rst_go", 32'(go_s[0]), 0);
        checkOutput("rst_wr_ready", 32'(wr_ready_s[0]), 1);
        checkOutput("rst_overflow", 32'(wr_overflow_s[0]), 0);
        checkOutput("rst_rd_data", 32'(rd_data_s[0]), 0);
        checkOutput("rst_rd_len", 32'(rd_len_s[0]), 0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt_s[0]), 0);

        // First frame A,B,C from idle: go right after the commit edge.
        applyStimulus(0, 1, WA, 0, 0, 0);
        applyStimulus(0, 1, WB, 0, 0, 0);
        applyStimulus(0, 1, WC, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("f1_go", 32'(go_s[0]), 1);
        checkOutput("f1_rd_len", 32'(rd_len_s[0]), 3);
        checkOutput("f1_frame_cnt", 32'(frame_cnt_s[0]), 1);
        checkOutput("f1_wr_ready", 32'(wr_ready_s[0]), 1);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("f1_go_drop", 32'(go_s[0]), 0);
        checkOutput("f1_rd0", 32'(rd_data_s[0]), 32'(WA));
        applyStimulus(0, 0, '0, 0, 0, 1);
        checkOutput("f1_rd1", 32'(rd_data_s[0]), 32'(WB));
        applyStimulus(0, 0, '0, 0, 0, 2);
        checkOutput("f1_rd2", 32'(rd_data_s[0]), 32'(WC));

        // Second frame D,E built while drawing; wr_ptr equals rd_addr on the first write.
        applyStimulus(0, 1, WD, 0, 0, 0);
        checkOutput("f2_front_intact", 32'(rd_data_s[0]), 32'(WA));
        applyStimulus(0, 1, WE, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("f2_wr_ready_wait", 32'(wr_ready_s[0]), 0);
        checkOutput("f2_no_go", 32'(go_s[0]), 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0);
        checkOutput("f2_go", 32'(go_s[0]), 1);
        checkOutput("f2_rd_len", 32'(rd_len_s[0]), 2);
        checkOutput("f2_wr_ready", 32'(wr_ready_s[0]), 1);
        checkOutput("f2_frame_cnt", 32'(frame_cnt_s[0]), 2);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("f2_rd0", 32'(rd_data_s[0]), 32'(WD));
        applyStimulus(0, 0, '0, 0, 0, 1);
        checkOutput("f2_rd1", 32'(rd_data_s[0]), 32'(WE));

        // Halt with nothing pending: repeat vs go idle.
        applyStimulus(0, 0, '0, 0, 1, 1);
        checkOutput("rep_go", 32'(go_s[0]), 1);
        checkOutput("rep_rd_len", 32'(rd_len_s[0]), 2);
        checkOutput("rep_frame_cnt", 32'(frame_cnt_s[0]), 3);
        checkOutput("idle_no_go", 32'(go_s[1]), 0);
        checkOutput("idle_frame_cnt", 32'(frame_cnt_s[1]), 2);
        applyStimulus(0, 0, '0, 0, 0, 1);
        checkOutput("rep_same_data", 32'(rd_data_s[0]), 32'(WE));
        applyStimulus(0, 1, WF, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("idle_commit_go", 32'(go_s[1]), 1);
        checkOutput("idle_rd_len", 32'(rd_len_s[1]), 1);
        checkOutput("rep_pending_no_go", 32'(go_s[0]), 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0);
        checkOutput("rep_f3_go", 32'(go_s[0]), 1);
        checkOutput("rep_f3_cnt", 32'(frame_cnt_s[0]), 4);
        checkOutput("idle_halt_no_go", 32'(go_s[1]), 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        checkOutput("f3_rd0", 32'(rd_data_s[0]), 32'(WF));

        // Overflow: ten writes into an eight-entry bank.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, ovfWord(k), 0, 0, 0);
            if (k == 7) checkOutput("ovf_before", 32'(wr_overflow_s[0]), 0);
            if (k == 8) checkOutput("ovf_after9", 32'(wr_overflow_s[0]), 1);
        end
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("ovf_cleared", 32'(wr_overflow_s[0]), 0);
        applyStimulus(0, 0, '0, 0, 1, 0);
        checkOutput("ovf_rd_len", 32'(rd_len_s[0]), 8);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, '0, 0, 0, AW'(k));
            checkOutput($sformatf("ovf_rd%0d", k), 32'(rd_data_s[0]),
                        (k < DEPTH) ? 32'(ovfWord(k)) : 32'h0);
        end
        applyStimulus(0, 0, '0, 0, 0, 16'hFFFF);
        checkOutput("rd_far_zero", 32'(rd_data_s[1]), 0);

        // Same-cycle write+commit+halt includes the word; empty commit is ignored.
        applyStimulus(0, 1, WG, 0, 0, 2);
        applyStimulus(0, 1, WH, 0, 0, 2);
        applyStimulus(0, 1, WI, 1, 1, 2);
        checkOutput("same_go", 32'(go_s[0]), 1);
        checkOutput("same_rd_len", 32'(rd_len_s[0]), 3);
        checkOutput("same_idle_go", 32'(go_s[1]), 1);
        applyStimulus(0, 0, '0, 1, 0, 2);
        checkOutput("zero_commit_ready", 32'(wr_ready_s[0]), 1);
        checkOutput("zero_commit_no_go", 32'(go_s[0]), 0);
        checkOutput("same_rd2", 32'(rd_data_s[0]), 32'(WI));
        applyStimulus(0, 0, '0, 0, 1, 0);
        checkOutput("zero_commit_rep_go", 32'(go_s[0]), 1);
        checkOutput("zero_commit_len", 32'(rd_len_s[0]), 3);

        // Reset while drawing with a frame pending.
        applyStimulus(0, 1, WJ, 0, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("prerst_wait", 32'(wr_ready_s[0]), 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("mrst_go", 32'(go_s[0]), 0);
        checkOutput("mrst_wr_ready", 32'(wr_ready_s[0]), 1);
        checkOutput("mrst_rd_len", 32'(rd_len_s[0]), 0);
        checkOutput("mrst_frame_cnt", 32'(frame_cnt_s[0]), 0);
        checkOutput("mrst_rd_data", 32'(rd_data_s[0]), 0);
        applyStimulus(0, 0, '0, 0, 1, 0);
        checkOutput("mrst_halt_no_go", 32'(go_s[0]), 0);
        checkOutput("mrst_halt_no_go_idle", 32'(go_s[1]), 0);
        applyStimulus(0, 0, '0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_list_pingpong.md
# display_list_pingpong

Double-buffered display-list store between the frame builder (memory manager) and the vector display engine. The writer fills a back bank while the display draws the front bank. Banks swap only on a frame boundary, via the go/halt handshake, so the display never reads a half-built frame. It is a parametrised successor to the single-RAM path: it adds configurable depth, frame length tracking, overflow detection, optional repeat-last-frame and a frame counter.

## Interface
Parameters:
- ADDRESSWIDTH, 16, width of write pointer, read address and lengths
- DATAWIDTH, 18, width of one display-list point word
- DEPTH, 1000, entries per bank (two banks total)
- REPEAT_LAST, 1, 1 = redraw the front frame when halted with nothing pending; 0 = go idle

Ports:
- clk  in  1  single clock for both sides
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write wr_data at the back-bank pointer, then increment the pointer
- wr_data  in  DATAWIDTH  point word
- wr_commit  in  1  close the back frame and mark it pending
- wr_ready  out  1  back bank accepts writes/commit
- wr_overflow  out  1  sticky: a write was dropped because the pointer reached DEPTH
- rd_addr  in  ADDRESSWIDTH  display read address into the front bank
- rd_data  out  DATAWIDTH  front-bank word, registered
- rd_len  out  ADDRESSWIDTH  entry count of the front frame
- go  out  1  one-cycle pulse: front frame valid, start drawing
- halt  in  1  one-cycle pulse from display: frame drawn
- frame_cnt  out  16  count of go pulses, wraps at 2^16

## Operation
- Writer FSM: W_FILL, W_WAIT.
  - W_FILL: wr_ready=1. wr_en with ptr<DEPTH writes and increments. wr_en with ptr==DEPTH is dropped and sets wr_overflow.
  - wr_commit in W_FILL with effective length ≥1 (a same-cycle wr_en counts): back_len ← length, pending ← 1, move to W_WAIT.
  - Commit with effective length 0 is ignored.
  - wr_overflow clears on an accepted commit.
  - W_WAIT: wr_ready=0. wr_en and wr_commit are ignored.
- Reader FSM: R_IDLE, R_DRAW.
  - Swap condition: the reader is in R_IDLE, or halt is asserted in R_DRAW, and a frame is pending. A commit accepted in the same cycle counts as pending.
  - Swap: toggle the bank-select bit, front_len ← back_len, pending ← 0, writer to W_FILL with ptr ← 0, reader to R_DRAW, go pulse.
  - halt in R_DRAW with no pending frame:
    - REPEAT_LAST=1: stay in R_DRAW, same bank, go pulse.
    - REPEAT_LAST=0: go to R_IDLE.
  - halt in R_IDLE is ignored.
- Read: rd_data ← bank[front][rd_addr]. If rd_addr ≥ DEPTH, rd_data ← 0.
- A frame whose points are written but not committed never reaches the front bank.

## Timing
- Reset values: go=0, wr_ready=1, wr_overflow=0, rd_data=0, rd_len=0, frame_cnt=0.
- Reset state: both FSMs in their first state (W_FILL, R_IDLE), pending=0, front bank=0, ptr=0.
- rst mid-frame discards both banks' lengths and the pending flag. Storage contents are not cleared.
- Read latency is 1 cycle: rd_addr at edge N gives rd_data after edge N+1.
- go is high in the cycle after the swap/repeat edge. rd_len and the bank select update on that same edge, so they are valid while go is high.
- frame_cnt increments on the edge where go rises.
- Commit to go: from R_IDLE, go is high 1 cycle after the commit edge. From R_DRAW, go is high 1 cycle after the halt edge.
- The minimum frame period is 2 cycles (go then halt).
- Writing to the back bank never alters front-bank read data, including when wr_ptr equals rd_addr.

## Structure
- vector_pkg holds the shared types: dl_wstate_t {W_FILL, W_WAIT} and dl_rstate_t {R_IDLE, R_DRAW}.
- One sub-module, dl_bank_ram: simple dual-port, 2*DEPTH×DATAWIDTH, one write port, one registered read port.
  - Address = {bank, offset} mapped to bank*DEPTH+offset.
- The FSMs, pointer, lengths and counter live in display_list_pingpong.

## Test plan
- Bench uses DEPTH=8.
- After reset, write 3 words A,B,C, then commit → go pulse 1 cycle after the commit edge; rd_len=3; rd_addr=0,1,2 return A,B,C one cycle later; frame_cnt=1; wr_ready=1.
- While drawing, write D,E and commit; then halt → go 1 cycle after halt; rd_len=2; reads return D,E; wr_ready goes 0 at commit and returns to 1 at swap.
- REPEAT_LAST=1: halt with nothing pending → go again, rd_len unchanged, same data, frame_cnt increments. REPEAT_LAST=0: no go, reader idle, a later commit gives go 1 cycle after the commit edge.
- Write 10 words then commit → wr_overflow=1 after the 9th write; rd_len=8; words 9–10 are absent; wr_overflow=0 after the commit.
- Same-cycle wr_en+wr_commit with halt → that word is included (rd_len is old ptr+1) and go follows in the next cycle. A zero-length commit is ignored (wr_ready stays 1, no go).
- Assert rst during R_DRAW with a frame pending → all outputs return to their reset values; the next halt produces no go.
